// File: rtl/cpu_sequencer.sv
// cpu_sequencer: loads a 4-bit program and steps the one-bit CPU until a step limit or fixed point
module cpu_sequencer #(
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_valid,
    input  logic [3:0]        prog_data,
    output logic              prog_ready,
    input  logic              start,
    input  logic              stop,
    input  logic [STEP_W-1:0] step_limit,
    input  logic              a_in,
    input  logic              p_in,
    output logic [1:0]        code,
    output logic              set_p,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              fixed,
    output logic [STEP_W-1:0] steps
);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t            state, state_nx;
    logic [3:0]        prog;
    logic              loaded;
    logic [STEP_W-1:0] limit;
    logic [1:0]        prev;
    logic              accept, launch, at_limit, at_fix;

    // A program offered in the same cycle as start counts as loaded.
    assign accept   = prog_valid && prog_ready;
    assign launch   = prog_ready && start && (loaded || prog_valid);
    assign at_limit = steps == limit;
    assign at_fix   = steps != '0 && {a_in, p_in} == prev;

    // State register; a reset drops the run and the program at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: stop outranks the limit, which outranks fixed-point detection.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (launch) state_nx = CLEAR;
            CLEAR:   state_nx = stop ? IDLE : (limit != '0 ? RUN : DONE);
            RUN:     if (stop) state_nx = IDLE;
                     else if (at_limit || at_fix) state_nx = DONE;
            DONE:    if (launch) state_nx = CLEAR;
                     else if (stop) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state; set_p only when RUN actually executes a step.
    always_comb begin
        prog_ready = state == IDLE || state == DONE;
        busy       = state == CLEAR || state == RUN;
        cpu_reset  = state != CLEAR;
        done       = state == DONE;
        set_p      = state == RUN && !stop && !at_limit && !at_fix;
        code       = state == RUN ? (p_in ? prog[3:2] : prog[1:0]) : 2'b00;
    end

    // Program store, run bookkeeping and the previous CPU state for fixed-point compare.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prog   <= '0;
            loaded <= 1'b0;
            limit  <= '0;
            steps  <= '0;
            prev   <= '0;
            fixed  <= 1'b0;
        end else begin
            if (accept) begin
                prog   <= prog_data;
                loaded <= 1'b1;
            end
            if (launch) begin
                limit <= step_limit;
                steps <= '0;
                fixed <= 1'b0;
            end
            if (state == RUN && !stop && !at_limit && at_fix) fixed <= 1'b1;
            if (set_p) begin
                steps <= steps + 1'b1;
                prev  <= {a_in, p_in};
            end
        end
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed and randomized runs checked against a per-run outcome model
module tb_cpu_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       prog_valid, start, stop, a_in, p_in;
    logic [3:0] prog_data;
    logic [7:0] step_limit;
    logic       prog_ready, set_p, cpu_reset, busy, done, fixed;
    logic [1:0] code;
    logic [7:0] steps;

    int         tests = 0;
    int         fails = 0;
    logic [1:0] s [16];
    logic [3:0] cur_prog;

    cpu_sequencer #(.STEP_W(8)) dut (
        .clk(clk), .reset(reset), .prog_valid(prog_valid), .prog_data(prog_data),
        .prog_ready(prog_ready), .start(start), .stop(stop), .step_limit(step_limit),
        .a_in(a_in), .p_in(p_in), .code(code), .set_p(set_p), .cpu_reset(cpu_reset),
        .busy(busy), .done(done), .fixed(fixed), .steps(steps)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: random CPU states, 1: all zero, 2: p toggles each step
    task automatic run(input logic [3:0] prg, input bit load, input int lim, input int stop_at, input int mode);
        int e;
        int kind;
        logic [1:0] exp_code;
        for (int k = 0; k < 16; k++)
            s[k] = mode == 0 ? 2'($urandom_range(0, 3)) : (mode == 1 ? 2'b00 : {1'b0, k[0]});
        if (load) cur_prog = prg;
        e = 0;
        kind = -1;
        if (lim == 0) kind = 1;
        while (kind < 0) begin
            if (e == stop_at) kind = 0;
            else if (e == lim) kind = 1;
            else if (e > 0 && s[e] == s[e-1]) kind = 2;
            else e++;
        end
        prog_valid = load;
        prog_data  = prg;
        start      = 1'b1;
        step_limit = 8'(lim);
        #1;
        chk("ready_before_start", 32'(prog_ready), 32'(1));
        tick();
        start      = 1'b0;
        prog_valid = 1'b0;
        chk("clear_cpu_reset", 32'(cpu_reset), 32'(0));
        chk("clear_busy", 32'(busy), 32'(1));
        chk("clear_set_p", 32'(set_p), 32'(0));
        chk("clear_ready", 32'(prog_ready), 32'(0));
        chk("clear_code", 32'(code), 32'(0));
        tick();
        for (int k = 0; k <= e && lim != 0; k++) begin
            {a_in, p_in} = s[k];
            stop         = k == stop_at;
            prog_valid   = 1'b1;
            prog_data    = ~cur_prog;
            exp_code     = s[k][0] ? cur_prog[3:2] : cur_prog[1:0];
            #1;
            chk("run_ready", 32'(prog_ready), 32'(0));
            chk("run_busy", 32'(busy), 32'(1));
            chk("run_code", 32'(code), 32'(exp_code));
            chk("run_set_p", 32'(set_p), 32'(k < e));
            tick();
            stop       = 1'b0;
            prog_valid = 1'b0;
        end
        if (kind == 0) begin
            chk("stop_busy", 32'(busy), 32'(0));
            chk("stop_done", 32'(done), 32'(0));
            chk("stop_steps", 32'(steps), 32'(e));
            chk("stop_ready", 32'(prog_ready), 32'(1));
        end else begin
            chk("end_done", 32'(done), 32'(1));
            chk("end_fixed", 32'(fixed), 32'(kind == 2));
            chk("end_steps", 32'(steps), 32'(e));
            chk("end_busy", 32'(busy), 32'(0));
            chk("end_set_p", 32'(set_p), 32'(0));
            chk("end_code", 32'(code), 32'(0));
            chk("end_cpu_reset", 32'(cpu_reset), 32'(1));
            chk("end_ready", 32'(prog_ready), 32'(1));
        end
    endtask

    initial begin
        reset      = 1'b0;
        prog_valid = 1'b0;
        prog_data  = '0;
        start      = 1'b0;
        stop       = 1'b0;
        step_limit = '0;
        a_in       = 1'b0;
        p_in       = 1'b0;
        cur_prog   = '0;
        repeat (2) tick();
        chk("rst_ready", 32'(prog_ready), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_fixed", 32'(fixed), 32'(0));
        chk("rst_steps", 32'(steps), 32'(0));
        chk("rst_cpu_reset", 32'(cpu_reset), 32'(1));
        chk("rst_set_p", 32'(set_p), 32'(0));
        chk("rst_code", 32'(code), 32'(0));
        reset = 1'b1;
        tick();
        // reset in the middle of a run
        prog_valid = 1'b1;
        prog_data  = 4'b1001;
        start      = 1'b1;
        step_limit = 8'd10;
        tick();
        prog_valid = 1'b0;
        start      = 1'b0;
        tick();
        p_in = 1'b1;
        tick();
        chk("midrun_busy", 32'(busy), 32'(1));
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_set_p", 32'(set_p), 32'(0));
        chk("midrst_steps", 32'(steps), 32'(0));
        chk("midrst_ready", 32'(prog_ready), 32'(1));
        chk("midrst_code", 32'(code), 32'(0));
        tick();
        reset = 1'b1;
        p_in  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_unloaded_busy", 32'(busy), 32'(0));
        tick();
        chk("start_unloaded_busy2", 32'(busy), 32'(0));
        run(4'b1001, 1'b1, 5, -1, 1);
        run(4'b1001, 1'b1, 4, -1, 2);
        run(4'b1001, 1'b0, 0, -1, 1);
        run(4'b1001, 1'b0, 10, 2, 2);
        run(4'b0110, 1'b1, 3, -1, 2);
        run(4'b0110, 1'b0, 3, -1, 2);
        repeat (40) begin
            int lim;
            int sa;
            lim = $urandom_range(0, 12);
            sa  = $urandom_range(0, 3) == 0 ? $urandom_range(0, lim) : -1;
            run(4'($urandom), 1'($urandom_range(0, 1)), lim, sa, 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
